// File: rtl/bidir_bus_ctrl_if.sv
// Request/grant/status bundle between the two requesters and bidir_bus_ctrl.
// The tri-state data bus stays a plain inout port on the controller.
interface bidir_bus_ctrl_if #(
    parameter int DW = 8
);
    logic          req0_valid;
    logic          req1_valid;
    logic          req0_we;
    logic          req1_we;
    logic [DW-1:0] req0_wdata;
    logic [DW-1:0] req1_wdata;
    logic          gnt0;
    logic          gnt1;
    logic          done;
    logic          done_id;
    logic [DW-1:0] rdata;
    logic          RD;

    // Requester / bench side
    modport master (
        output req0_valid, req1_valid, req0_we, req1_we, req0_wdata, req1_wdata,
        input  gnt0, gnt1, done, done_id, rdata, RD
    );

    // Controller side
    modport slave (
        input  req0_valid, req1_valid, req0_we, req1_we, req0_wdata, req1_wdata,
        output gnt0, gnt1, done, done_id, rdata, RD
    );
endinterface

// File: rtl/bidir_bus_ctrl.sv
// Two-requester controller for a shared bidirectional bus with turnaround cycle.
// Define BIDIR_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module bidir_bus_ctrl #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    bidir_bus_ctrl_if.slave    bus_if,
    inout  wire  [DW-1:0]      data_bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_TURN
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          id_q, id_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done_q, done_d;
    logic          done_id_q, done_id_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rd_q, rd_d;
    logic          oe_q, oe_d;
    logic          any_req;
    logic          win_id;
`ifdef BIDIR_RR_EN
    logic          last_q, last_d;
`endif

    assign data_bus       = oe_q ? wdata_q : {DW{1'bz}};
    assign bus_if.gnt0    = gnt0_q;
    assign bus_if.gnt1    = gnt1_q;
    assign bus_if.done    = done_q;
    assign bus_if.done_id = done_id_q;
    assign bus_if.rdata   = rdata_q;
    assign bus_if.RD      = rd_q;

    always_comb begin
        any_req = bus_if.req0_valid | bus_if.req1_valid;
`ifdef BIDIR_RR_EN
        // On a tie the requester not granted last wins
        if (bus_if.req0_valid && bus_if.req1_valid) begin
            win_id = ~last_q;
        end else begin
            win_id = ~bus_if.req0_valid;
        end
`else
        win_id = ~bus_if.req0_valid;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        id_d      = id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        rdata_d   = rdata_q;
        rd_d      = 1'b0;
        oe_d      = 1'b0;
`ifdef BIDIR_RR_EN
        last_d    = last_q;
`endif
        // rd_d/oe_d describe the state being entered so RD and oe stay registered
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    id_d    = win_id;
                    we_d    = win_id ? bus_if.req1_we    : bus_if.req0_we;
                    wdata_d = win_id ? bus_if.req1_wdata : bus_if.req0_wdata;
                    gnt0_d  = ~win_id;
                    gnt1_d  = win_id;
                    cnt_d   = '0;
`ifdef BIDIR_RR_EN
                    last_d  = win_id;
`endif
                    if (we_d) begin
                        state_d = S_WRITE;
                        oe_d    = 1'b1;
                    end else begin
                        state_d = S_READ;
                        rd_d    = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                state_d   = S_TURN;
                done_d    = 1'b1;
                done_id_d = id_q;
            end
            S_READ: begin
                if (cnt_q == 4'(RD_LAT)) begin
                    rdata_d   = data_bus;
                    state_d   = S_TURN;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    rd_d  = 1'b1;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            id_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            rdata_q   <= '0;
            rd_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            id_q      <= id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            oe_q      <= oe_d;
        end
    end

`ifdef BIDIR_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl with an inline device model that returns 2x the written value.
`timescale 1ns/1ps
module tb_bidir_bus_ctrl;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wire [DW-1:0] data_bus;
    bidir_bus_ctrl_if #(.DW(DW)) bif ();

    bidir_bus_ctrl #(.DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_if   (bif),
        .data_bus (data_bus)
    );

    // Device: captures while the controller drives, answers with 2x after RD_LAT cycles
    wire           dut_oe = dut.oe_q;
    logic [DW-1:0] dev_reg = '0;
    logic [3:0]    dev_cnt = '0;
    wire  [DW-1:0] dev_out = (dev_cnt >= 4'(RD_LAT)) ? {dev_reg[DW-2:0], 1'b0} : 8'hEE;
    assign data_bus = bif.RD ? dev_out : {DW{1'bz}};

    always @(posedge clk) begin
        if (dut_oe) dev_reg <= data_bus;
        if (bif.RD) dev_cnt <= (dev_cnt == 4'hF) ? dev_cnt : dev_cnt + 4'd1;
        else        dev_cnt <= '0;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Bus-ownership monitor
    int   contention = 0;
    int   gap_viol   = 0;
    logic rd_p1 = 1'b0, rd_p2 = 1'b0, oe_p1 = 1'b0;
    always @(negedge clk) begin
        if (bif.RD && dut_oe) contention++;
        if (dut_oe && (rd_p1 || rd_p2)) gap_viol++;
        if (bif.RD && oe_p1) gap_viol++;
        rd_p2 <= rd_p1;
        rd_p1 <= bif.RD;
        oe_p1 <= dut_oe;
    end

    // Reference model: arbitration pointer, device contents, held read data
    logic [7:0] m_mem   = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    bit         m_last  = 1'b1;

    function automatic bit m_pick(input bit v0, input bit v1);
`ifdef BIDIR_RR_EN
        if (v0 && v1) return (m_last == 1'b1) ? 1'b0 : 1'b1;
`else
        if (v0 && v1) return 1'b0;
`endif
        return v0 ? 1'b0 : 1'b1;
    endfunction

    task automatic m_apply(input bit id, input bit we, input logic [7:0] wd);
        m_last = id;
        if (we) m_mem = wd;
        else    m_rdata = 8'((int'(m_mem) * 2) % 256);
    endtask

    task automatic set_req(input bit id, input bit v, input bit we, input logic [7:0] wd);
        if (id) begin
            bif.req1_valid = v; bif.req1_we = we; bif.req1_wdata = wd;
        end else begin
            bif.req0_valid = v; bif.req0_we = we; bif.req0_wdata = wd;
        end
    endtask

    // Single transaction from an idle controller; latencies counted in edges from request
    task automatic run_txn(input bit id, input bit we, input logic [7:0] wd,
                           output int glat, output int dlat, output logic [7:0] rd, output bit did);
        int cyc;
        cyc = 0; glat = -1; dlat = -1; rd = '0; did = 1'b0;
        set_req(id, 1'b1, we, wd);
        while (dlat < 0 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if ((id ? bif.gnt1 : bif.gnt0) && glat < 0) begin
                glat = cyc;
                set_req(id, 1'b0, we, wd);
            end
            if (bif.done) begin
                dlat = cyc; rd = bif.rdata; did = bif.done_id;
            end
        end
        set_req(id, 1'b0, we, wd);
        @(posedge clk); #1;
    endtask

    // Up to two simultaneous requests, checked against the model's service order
    task automatic serve_pair(input bit v0, input bit v1, input bit w0, input bit w1,
                              input logic [7:0] d0, input logic [7:0] d1, input string tag);
        bit         e_id [2];
        logic [7:0] e_rd [2];
        int n, dn, cyc;
        bit w;
        n = 0;
        if (v0 && v1) begin
            w = m_pick(1'b1, 1'b1);
            m_apply(w, w ? w1 : w0, w ? d1 : d0);
            e_id[0] = w; e_rd[0] = m_rdata;
            m_apply(~w, w ? w0 : w1, w ? d0 : d1);
            e_id[1] = ~w; e_rd[1] = m_rdata;
            n = 2;
        end else begin
            w = m_pick(v0, v1);
            m_apply(w, w ? w1 : w0, w ? d1 : d0);
            e_id[0] = w; e_rd[0] = m_rdata;
            n = 1;
        end
        set_req(1'b0, v0, w0, d0);
        set_req(1'b1, v1, w1, d1);
        dn = 0; cyc = 0;
        while (dn < n && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (bif.gnt0) bif.req0_valid = 1'b0;
            if (bif.gnt1) bif.req1_valid = 1'b0;
            if (bif.done) begin
                check({tag, "_done_id"}, 32'(bif.done_id), 32'(e_id[dn]));
                check({tag, "_rdata"}, 32'(bif.rdata), 32'(e_rd[dn]));
                dn++;
            end
        end
        check({tag, "_done_count"}, dn, n);
        bif.req0_valid = 1'b0;
        bif.req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit         id;
        bit         we;
        logic [7:0] wd;
        int         glat;
        int         dlat;
        logic [7:0] rdata;
        bit         did;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt [8];
        int         glat, dlat;
        logic [7:0] rd;
        bit         did;

        vt[0] = '{1'b0, 1'b1, 8'h24, 1, 2,          8'h00, 1'b0};
        vt[1] = '{1'b0, 1'b0, 8'h00, 1, 2 + RD_LAT, 8'h48, 1'b0};
        vt[2] = '{1'b1, 1'b1, 8'h7F, 1, 2,          8'h48, 1'b1};
        vt[3] = '{1'b1, 1'b0, 8'h00, 1, 2 + RD_LAT, 8'hFE, 1'b1};
        vt[4] = '{1'b0, 1'b1, 8'h80, 1, 2,          8'hFE, 1'b0};
        vt[5] = '{1'b1, 1'b0, 8'h00, 1, 2 + RD_LAT, 8'h00, 1'b1};
        vt[6] = '{1'b1, 1'b1, 8'hFF, 1, 2,          8'h00, 1'b1};
        vt[7] = '{1'b0, 1'b0, 8'h00, 1, 2 + RD_LAT, 8'hFE, 1'b0};

        bif.req0_valid = 1'b0; bif.req0_we = 1'b0; bif.req0_wdata = '0;
        bif.req1_valid = 1'b0; bif.req1_we = 1'b0; bif.req1_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_RD", 32'(bif.RD), 0);
        check("rst_oe", 32'(dut_oe), 0);
        check("rst_gnt", 32'({bif.gnt1, bif.gnt0}), 0);
        check("rst_done", 32'({bif.done, bif.done_id}), 0);
        check("rst_rdata", 32'(bif.rdata), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(vt[i].id, vt[i].we, vt[i].wd, glat, dlat, rd, did);
            check($sformatf("vec%0d_gnt_lat", i), glat, vt[i].glat);
            check($sformatf("vec%0d_done_lat", i), dlat, vt[i].dlat);
            check($sformatf("vec%0d_done_id", i), 32'(did), 32'(vt[i].did));
            check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].rdata));
            m_apply(vt[i].id, vt[i].we, vt[i].wd);
        end

        // Back-to-back write 0x11 / read, 20 pairs, next request raised on each grant
        begin
            int k, dn, cyc, last_done;
            k = 0; dn = 0; cyc = 0; last_done = 0;
            set_req(1'b0, 1'b1, 1'b1, 8'h11);
            while (dn < 40 && cyc < 400) begin
                @(posedge clk); #1; cyc++;
                if (bif.gnt0) begin
                    k++;
                    if (k < 40) set_req(1'b0, 1'b1, (k % 2) == 0, 8'h11);
                    else        bif.req0_valid = 1'b0;
                end
                if (bif.done) begin
                    dn++;
                    last_done = cyc;
                    if (dn % 2 == 0) check("b2b_rdata", 32'(bif.rdata), 32'h22);
                end
            end
            bif.req0_valid = 1'b0;
            check("b2b_done_count", dn, 40);
            check("b2b_cycles", last_done, 20 * (3 + RD_LAT + 3) - 1);
            m_apply(1'b0, 1'b1, 8'h11);
            m_apply(1'b0, 1'b0, 8'h00);
            @(posedge clk); #1;
        end

        // Both requesters held valid for 4 grants
        begin
            int ng, cyc;
            bit e;
            ng = 0; cyc = 0;
            set_req(1'b0, 1'b1, 1'b1, 8'hA5);
            set_req(1'b1, 1'b1, 1'b1, 8'h5A);
            while (ng < 4 && cyc < 100) begin
                @(posedge clk); #1; cyc++;
                if (bif.gnt0 || bif.gnt1) begin
                    e = m_pick(1'b1, 1'b1);
                    m_apply(e, 1'b1, e ? 8'h5A : 8'hA5);
                    check($sformatf("hold_gnt%0d", ng), 32'({bif.gnt1, bif.gnt0}), e ? 32'h2 : 32'h1);
                    ng++;
                    if (ng == 4) begin
                        bif.req0_valid = 1'b0;
                        bif.req1_valid = 1'b0;
                    end
                end
            end
            check("hold_grants", ng, 4);
            repeat (2) @(posedge clk);
            #1;
            check("hold_dev_reg", 32'(dev_reg), 32'(m_mem));
        end

        // Randomized pairs against the model
        for (int it = 0; it < 30; it++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v1 = 1'b1;
            serve_pair(v0, v1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rnd");
        end

        // Reset during the second READ cycle
        begin
            int dcount;
            set_req(1'b0, 1'b1, 1'b0, 8'h00);
            @(posedge clk); #1;
            check("mid_gnt0", 32'(bif.gnt0), 1);
            bif.req0_valid = 1'b0;
            @(posedge clk); #2;
            check("mid_RD_before", 32'(bif.RD), 1);
            rst_n = 1'b0;
            #1;
            check("mid_RD_after", 32'(bif.RD), 0);
            check("mid_oe_after", 32'(dut_oe), 0);
            check("mid_rdata_after", 32'(bif.rdata), 0);
            m_rdata = 8'h00;
            m_last  = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk) rst_n = 1'b1;
            dcount = 0;
            repeat (5) begin
                @(posedge clk); #1;
                if (bif.done || bif.gnt0 || bif.gnt1) dcount++;
            end
            check("mid_no_done", dcount, 0);
        end

        // First tie after reset goes to req0 in both builds
        serve_pair(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hC3, "post_rst_tie");

        run_txn(1'b1, 1'b1, 8'h7E, glat, dlat, rd, did);
        check("r1w_gnt_lat", glat, 1);
        check("r1w_done_lat", dlat, 2);
        check("r1w_done_id", 32'(did), 1);
        m_apply(1'b1, 1'b1, 8'h7E);
        run_txn(1'b1, 1'b0, 8'h00, glat, dlat, rd, did);
        m_apply(1'b1, 1'b0, 8'h00);
        check("r1r_done_lat", dlat, 2 + RD_LAT);
        check("r1r_rdata", 32'(rd), 32'(m_rdata));
        check("r1r_done_id", 32'(did), 1);

        // Idle stability
        begin
            int idle_bad;
            idle_bad = 0;
            repeat (50) begin
                @(negedge clk);
                if (bif.gnt0 || bif.gnt1 || bif.done || bif.RD || dut_oe) idle_bad++;
            end
            check("idle_quiet", idle_bad, 0);
        end

        check("no_contention", contention, 0);
        check("turnaround_gap", gap_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
